// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode. Buffers up to DEPTH {pc, ir}
// pairs in FIFO order, with a valid/ready handshake on each side, and
// presents the head entry already split into decode fields and immediates.
// When the queue is empty, the output shows a NOP bubble.
module if_id_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] NOP_INSN = 32'h00000013
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                ir_in,
   input  logic [31:0]                pc_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                ir_out,
   output logic [31:0]                pc_out,
   output logic [6:0]                 opcode,
   output logic [2:0]                 funct3,
   output logic [6:0]                 funct7,
   output logic [4:0]                 rs1,
   output logic [4:0]                 rs2,
   output logic [4:0]                 rd,
   output logic [31:0]                i_imm,
   output logic [31:0]                s_imm,
   output logic [31:0]                b_imm,
   output logic [31:0]                u_imm,
   output logic [31:0]                j_imm,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [31:0]   ir_mem [DEPTH];
   logic [31:0]   pc_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          push;
   logic          pop;
   logic          clear;

   assign out_valid = (count != '0);
   // Pushing into a full queue is allowed when the head is being consumed
   // in the same cycle. The freed slot is the one the write pointer addresses.
   assign in_ready  = (count != CW'(DEPTH)) | out_ready;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign clear     = rst | flush;

   // Pointers and occupancy. The pointers wrap by explicit compare, so DEPTH
   // does not need to be a power of two.
   always_ff @(posedge clk) begin
      if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // Entry storage. It has no reset, because the outputs are masked by the occupancy.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         ir_mem[wr_ptr] <= ir_in;
         pc_mem[wr_ptr] <= pc_in;
      end
   end

   // Head entry, or the NOP bubble when the queue is empty. This path reads only registered state.
   always_comb begin
      ir_out = NOP_INSN;
      pc_out = '0;
      if (out_valid) begin
         ir_out = ir_mem[rd_ptr];
         pc_out = pc_mem[rd_ptr];
      end
   end

   assign opcode = ir_out[6:0];
   assign rd     = ir_out[11:7];
   assign funct3 = ir_out[14:12];
   assign rs1    = ir_out[19:15];
   assign rs2    = ir_out[24:20];
   assign funct7 = ir_out[31:25];

   assign i_imm = {{20{ir_out[31]}}, ir_out[31:20]};
   assign s_imm = {{20{ir_out[31]}}, ir_out[31:25], ir_out[11:7]};
   assign b_imm = {{19{ir_out[31]}}, ir_out[31], ir_out[7], ir_out[30:25],
                   ir_out[11:8], 1'b0};
   assign u_imm = {ir_out[31:12], 12'h000};
   assign j_imm = {{11{ir_out[31]}}, ir_out[31], ir_out[19:12], ir_out[20],
                   ir_out[30:21], 1'b0};

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue. It exercises a DEPTH=4 instance and a DEPTH=3
// instance side by side. Scoreboard queues track the expected contents.
module tb_if_id_queue;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // DEPTH=4 instance
   logic        flush4 = 0, in_valid4 = 0, out_ready4 = 0;
   logic [31:0] ir_in4 = 0, pc_in4 = 0;
   logic        in_ready4, out_valid4;
   logic [31:0] ir_out4, pc_out4, i_imm4, s_imm4, b_imm4, u_imm4, j_imm4;
   logic [6:0]  opcode4, funct7_4;
   logic [2:0]  funct3_4;
   logic [4:0]  rs1_4, rs2_4, rd4;
   logic [2:0]  count4;

   // DEPTH=3 instance
   logic        flush3 = 0, in_valid3 = 0, out_ready3 = 0;
   logic [31:0] ir_in3 = 0, pc_in3 = 0;
   logic        in_ready3, out_valid3;
   logic [31:0] ir_out3, pc_out3, i_imm3, s_imm3, b_imm3, u_imm3, j_imm3;
   logic [6:0]  opcode3, funct7_3;
   logic [2:0]  funct3_3;
   logic [4:0]  rs1_3, rs2_3, rd3;
   logic [1:0]  count3;

   logic [63:0] sb4[$];
   logic [63:0] sb3[$];

   if_id_queue #(.DEPTH(4)) u_q4 (
      .clk(clk), .rst(rst), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
      .ir_in(ir_in4), .pc_in(pc_in4), .out_valid(out_valid4), .out_ready(out_ready4),
      .ir_out(ir_out4), .pc_out(pc_out4), .opcode(opcode4), .funct3(funct3_4),
      .funct7(funct7_4), .rs1(rs1_4), .rs2(rs2_4), .rd(rd4), .i_imm(i_imm4),
      .s_imm(s_imm4), .b_imm(b_imm4), .u_imm(u_imm4), .j_imm(j_imm4), .count(count4));

   if_id_queue #(.DEPTH(3)) u_q3 (
      .clk(clk), .rst(rst), .flush(flush3), .in_valid(in_valid3), .in_ready(in_ready3),
      .ir_in(ir_in3), .pc_in(pc_in3), .out_valid(out_valid3), .out_ready(out_ready3),
      .ir_out(ir_out3), .pc_out(pc_out3), .opcode(opcode3), .funct3(funct3_3),
      .funct7(funct7_3), .rs1(rs1_3), .rs2(rs2_3), .rd(rd3), .i_imm(i_imm3),
      .s_imm(s_imm3), .b_imm(b_imm3), .u_imm(u_imm3), .j_imm(j_imm3), .count(count3));

   // Advance the scoreboards with the currently driven inputs, then move past the clock edge.
   task automatic tick();
      bit pu, po;
      if (rst || flush4) sb4.delete();
      else begin
         po = (sb4.size() != 0) && out_ready4;
         pu = in_valid4 && ((sb4.size() != 4) || out_ready4);
         if (po) void'(sb4.pop_front());
         if (pu) sb4.push_back({pc_in4, ir_in4});
      end
      if (rst || flush3) sb3.delete();
      else begin
         po = (sb3.size() != 0) && out_ready3;
         pu = in_valid3 && ((sb3.size() != 3) || out_ready3);
         if (po) void'(sb3.pop_front());
         if (pu) sb3.push_back({pc_in3, ir_in3});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      vectors++; if (out_valid4 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", out_valid4); end
      vectors++; if (count4 !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count4); end
      vectors++; if (ir_out4 !== 32'h00000013) begin miscompares++; $display("FAIL reset_ir_out got %h exp 00000013", ir_out4); end
      vectors++; if (pc_out4 !== 32'h0) begin miscompares++; $display("FAIL reset_pc_out got %h exp 0", pc_out4); end
      vectors++; if (opcode4 !== 7'h13) begin miscompares++; $display("FAIL reset_opcode got %h exp 13", opcode4); end
      vectors++; if ({rd4, rs1_4, rs2_4, funct3_4, funct7_4} !== 25'd0) begin miscompares++; $display("FAIL reset_fields got %h exp 0", {rd4, rs1_4, rs2_4, funct3_4, funct7_4}); end
      vectors++; if ({i_imm4, s_imm4, b_imm4, u_imm4, j_imm4} !== 160'd0) begin miscompares++; $display("FAIL reset_imms got %h exp 0", {i_imm4, s_imm4, b_imm4, u_imm4, j_imm4}); end
      vectors++; if (in_ready4 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready4); end
      vectors++; if (count3 !== 2'd0) begin miscompares++; $display("FAIL reset_count3 got %0d exp 0", count3); end
   endtask

   task automatic test_fill_drain();
      logic [31:0] irs [4] = '{32'h00500093, 32'h00208133, 32'hFE010EE3, 32'h123452B7};
      out_ready4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid4 = 1'b1; ir_in4 = irs[k]; pc_in4 = 32'(4 * k);
         #1;
         vectors++; if (in_ready4 !== 1'b1) begin miscompares++; $display("FAIL fill_in_ready[%0d] got %b exp 1", k, in_ready4); end
         tick();
      end
      in_valid4 = 1'b1; ir_in4 = 32'hDEADBEEF; pc_in4 = 32'h10;
      #1;
      vectors++; if (count4 !== 3'd4) begin miscompares++; $display("FAIL full_count got %0d exp 4", count4); end
      vectors++; if (in_ready4 !== 1'b0) begin miscompares++; $display("FAIL full_in_ready got %b exp 0", in_ready4); end
      vectors++; if (i_imm4 !== 32'd5 || rd4 !== 5'd1 || opcode4 !== 7'h13) begin miscompares++; $display("FAIL head_addi got imm %h rd %0d op %h exp 5 1 13", i_imm4, rd4, opcode4); end
      tick();
      in_valid4 = 1'b0;
      #1;
      vectors++; if (count4 !== 3'd4) begin miscompares++; $display("FAIL full_refuse_count got %0d exp 4", count4); end
      for (int k = 0; k < 4; k++) begin
         out_ready4 = 1'b1;
         #1;
         vectors++; if (ir_out4 !== irs[k] || pc_out4 !== 32'(4 * k)) begin miscompares++; $display("FAIL drain_order[%0d] got %h@%h exp %h@%h", k, ir_out4, pc_out4, irs[k], 32'(4 * k)); end
         if (k == 1) begin
            vectors++; if (rd4 !== 5'd2 || rs1_4 !== 5'd1 || rs2_4 !== 5'd2 || funct7_4 !== 7'd0 || opcode4 !== 7'h33) begin miscompares++; $display("FAIL rtype_fields got rd %0d rs1 %0d rs2 %0d f7 %h op %h exp 2 1 2 0 33", rd4, rs1_4, rs2_4, funct7_4, opcode4); end
         end
         if (k == 2) begin
            vectors++; if (b_imm4 !== 32'hFFFFFFFC || s_imm4 !== 32'hFFFFFFFD || rs1_4 !== 5'd2 || opcode4 !== 7'h63) begin miscompares++; $display("FAIL branch_fields got b %h s %h rs1 %0d op %h exp fffffffc fffffffd 2 63", b_imm4, s_imm4, rs1_4, opcode4); end
         end
         if (k == 3) begin
            vectors++; if (u_imm4 !== 32'h12345000 || rd4 !== 5'd5 || opcode4 !== 7'h37) begin miscompares++; $display("FAIL lui_fields got u %h rd %0d op %h exp 12345000 5 37", u_imm4, rd4, opcode4); end
         end
         tick();
      end
      out_ready4 = 1'b0;
      #1;
      vectors++; if (out_valid4 !== 1'b0 || count4 !== 3'd0) begin miscompares++; $display("FAIL drained got valid %b count %0d exp 0 0", out_valid4, count4); end
   endtask

   task automatic test_back_to_back();
      out_ready4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid4 = 1'b1; ir_in4 = 32'hA0000000 | 32'(k); pc_in4 = 32'h100 + 32'(4 * k);
         tick();
      end
      for (int c = 0; c < 10; c++) begin
         in_valid4 = 1'b1; out_ready4 = 1'b1;
         ir_in4 = 32'hA0000000 | 32'(c + 4); pc_in4 = 32'h100 + 32'(4 * (c + 4));
         #1;
         vectors++; if (count4 !== 3'd4 || in_ready4 !== 1'b1) begin miscompares++; $display("FAIL stream_full[%0d] got count %0d rdy %b exp 4 1", c, count4, in_ready4); end
         vectors++; if (pc_out4 !== 32'h100 + 32'(4 * c) || ir_out4 !== (32'hA0000000 | 32'(c)) || pc_out4 !== sb4[0][63:32]) begin miscompares++; $display("FAIL stream_order[%0d] got %h@%h exp %h@%h", c, ir_out4, pc_out4, 32'hA0000000 | 32'(c), 32'h100 + 32'(4 * c)); end
         tick();
      end
      in_valid4 = 1'b0;
      for (int c = 10; c < 14; c++) begin
         #1;
         vectors++; if (pc_out4 !== 32'h100 + 32'(4 * c) || ir_out4 !== (32'hA0000000 | 32'(c))) begin miscompares++; $display("FAIL stream_drain[%0d] got %h@%h exp %h@%h", c, ir_out4, pc_out4, 32'hA0000000 | 32'(c), 32'h100 + 32'(4 * c)); end
         tick();
      end
      out_ready4 = 1'b0;
      #1;
      vectors++; if (count4 !== 3'(sb4.size()) || out_valid4 !== 1'b0) begin miscompares++; $display("FAIL stream_empty got count %0d valid %b exp 0 0", count4, out_valid4); end
   endtask

   task automatic test_flush();
      out_ready4 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid4 = 1'b1; ir_in4 = 32'h00100093 + 32'(k); pc_in4 = 32'h200 + 32'(4 * k);
         tick();
      end
      flush4 = 1'b1; in_valid4 = 1'b1; out_ready4 = 1'b1; ir_in4 = 32'h00000BAD; pc_in4 = 32'h20C;
      #1;
      vectors++; if (in_ready4 !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready got %b exp 1", in_ready4); end
      tick();
      flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
      #1;
      vectors++; if (count4 !== 3'd0 || out_valid4 !== 1'b0) begin miscompares++; $display("FAIL flush_empty got count %0d valid %b exp 0 0", count4, out_valid4); end
      vectors++; if (ir_out4 !== 32'h00000013 || pc_out4 !== 32'h0) begin miscompares++; $display("FAIL flush_nop got %h@%h exp 00000013@0", ir_out4, pc_out4); end
      in_valid4 = 1'b1; ir_in4 = 32'h00700093; pc_in4 = 32'h300;
      tick();
      in_valid4 = 1'b0;
      #1;
      vectors++; if (ir_out4 !== 32'h00700093 || pc_out4 !== 32'h300 || count4 !== 3'd1) begin miscompares++; $display("FAIL post_flush_push got %h@%h cnt %0d exp 00700093@300 1", ir_out4, pc_out4, count4); end
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
   endtask

   task automatic test_latency();
      in_valid4 = 1'b1; ir_in4 = 32'h0000006F; pc_in4 = 32'h400;
      #1;
      vectors++; if (out_valid4 !== 1'b0 || ir_out4 !== 32'h00000013) begin miscompares++; $display("FAIL no_bypass got valid %b ir %h exp 0 00000013", out_valid4, ir_out4); end
      tick();
      in_valid4 = 1'b0;
      #1;
      vectors++; if (out_valid4 !== 1'b1 || ir_out4 !== 32'h0000006F || pc_out4 !== 32'h400) begin miscompares++; $display("FAIL jal_visible got valid %b %h@%h exp 1 0000006f@400", out_valid4, ir_out4, pc_out4); end
      vectors++; if (j_imm4 !== 32'h0 || opcode4 !== 7'h6F) begin miscompares++; $display("FAIL jal_fields got j %h op %h exp 0 6f", j_imm4, opcode4); end
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
   endtask

   task automatic test_depth3();
      int pushed = 0;
      int popped = 0;
      for (int c = 0; c < 60 && popped < 7; c++) begin
         in_valid3  = (pushed < 7) && (c % 3 != 2);
         out_ready3 = (c % 4 >= 2) || (c > 12);
         ir_in3 = 32'hC0000000 | 32'(pushed); pc_in3 = 32'(4 * pushed);
         #1;
         vectors++; if (count3 !== 2'(sb3.size()) || out_valid3 !== (sb3.size() != 0)) begin miscompares++; $display("FAIL d3_count[%0d] got %0d valid %b exp %0d", c, count3, out_valid3, sb3.size()); end
         vectors++; if (in_ready3 !== ((sb3.size() != 3) || out_ready3)) begin miscompares++; $display("FAIL d3_in_ready[%0d] got %b exp %b", c, in_ready3, (sb3.size() != 3) || out_ready3); end
         if (sb3.size() != 0) begin
            vectors++; if (ir_out3 !== (32'hC0000000 | 32'(popped)) || pc_out3 !== 32'(4 * popped)) begin miscompares++; $display("FAIL d3_order[%0d] got %h@%h exp %h@%h", popped, ir_out3, pc_out3, 32'hC0000000 | 32'(popped), 32'(4 * popped)); end
            if (out_ready3) popped++;
         end
         if (in_valid3 && ((sb3.size() != 3) || out_ready3)) pushed++;
         tick();
      end
      in_valid3 = 1'b0; out_ready3 = 1'b0;
      vectors++; if (popped != 7) begin miscompares++; $display("FAIL d3_timeout got %0d pops exp 7", popped); end
      for (int k = 0; k < 2; k++) begin
         in_valid3 = 1'b1; ir_in3 = 32'hE0000000 | 32'(k); pc_in3 = 32'h500 + 32'(4 * k);
         tick();
      end
      #1;
      vectors++; if (count3 !== 2'd2) begin miscompares++; $display("FAIL d3_prefill got %0d exp 2", count3); end
      rst = 1'b1;
      tick();
      rst = 1'b0; in_valid3 = 1'b0;
      #1;
      vectors++; if (count3 !== 2'd0 || out_valid3 !== 1'b0 || ir_out3 !== 32'h00000013) begin miscompares++; $display("FAIL d3_midreset got cnt %0d valid %b ir %h exp 0 0 00000013", count3, out_valid3, ir_out3); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_flush();
      test_latency();
      test_depth3();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
